// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debouncer.
// Holds the filter FSM state type and the level/state mapping helpers.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } deb_state_t;

  // Debounced level presented while the FSM sits in a given state.
  function automatic logic level_of(input deb_state_t s);
    return (s == STABLE_HI) || (s == PEND_LO);
  endfunction

  function automatic deb_state_t stable_of(input logic lvl);
    return lvl ? STABLE_HI : STABLE_LO;
  endfunction

endpackage

// File: rtl/sync_m.sv
// Multi-flop synchronizer for a single asynchronous level.
// Output is the last flop of a STAGES-deep chain; reset loads INIT everywhere.
module sync_m #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{INIT}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_m.sv
// Debouncer: synchronizes a raw level, accepts a new level only after it holds
// for FILTER consecutive clocks, and emits registered rise/fall pulses.
module debounce_m
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER      = 16,
  parameter logic INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = $clog2(FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILTER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             in_s;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_d, rise_d, fall_d;

  sync_m #(
    .STAGES (SYNC_STAGES),
    .INIT   (INIT)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in),
    .q     (in_s)
  );

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= stable_of(INIT);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the edge that enters PEND counts as the first of FILTER edges,
  // so the load value is FILTER-1 and the terminal count is 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      STABLE_LO: begin
        if (in_s) begin
          if (FILTER == 1) begin
            state_d = STABLE_HI;
          end else begin
            state_d = PEND_HI;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      PEND_HI: begin
        if (!in_s) begin
          state_d = STABLE_LO;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = STABLE_HI;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!in_s) begin
          if (FILTER == 1) begin
            state_d = STABLE_LO;
          end else begin
            state_d = PEND_LO;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      PEND_LO: begin
        if (in_s) begin
          state_d = STABLE_HI;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = STABLE_LO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = stable_of(out);
      end
    endcase
  end

  // Output decode; pulses come from comparing next level with the held level
  always_comb begin
    out_d  = level_of(state_d);
    rise_d = out_d & ~out;
    fall_d = ~out_d & out;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= INIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      out  <= out_d;
      rise <= rise_d;
      fall <= fall_d;
    end
  end

endmodule

// File: tb/tb_debounce_m.sv
// Directed bench for debounce_m: table-driven filter vectors on a FILTER=4
// instance plus hand-written reset and FILTER=1/INIT=1 sequences.
module tb_debounce_m;

  typedef struct {
    logic       in;
    logic [2:0] exp;  // {out, rise, fall} after the next rising edge
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_raw = 1'b0;
  logic out, rise, fall;
  logic rst1_n = 1'b0;
  logic in1 = 1'b1;
  logic out1, rise1, fall1;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  debounce_m #(.SYNC_STAGES(2), .FILTER(4), .INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_raw), .out(out), .rise(rise), .fall(fall)
  );

  debounce_m #(.SYNC_STAGES(2), .FILTER(1), .INIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .in(in1), .out(out1), .rise(rise1), .fall(fall1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [2:0] act,
                       input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: {out,rise,fall} got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic i, input logic [2:0] e, input int n);
    vec_t v;
    v.in  = i;
    v.exp = e;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    // Each row: in is applied just after edge Er, outputs checked after Er+1.
    add(0, 3'b000, 8);
    // Step 0->1: rise six edges after launch
    add(1, 3'b000, 5); add(1, 3'b110, 1); add(1, 3'b100, 4);
    add(0, 3'b100, 5); add(0, 3'b001, 1); add(0, 3'b000, 6);
    // Three-cycle pulse is rejected
    add(1, 3'b000, 3); add(0, 3'b000, 9);
    // Four-cycle pulse passes, then falls
    add(1, 3'b000, 4); add(0, 3'b000, 1); add(0, 3'b110, 1); add(0, 3'b100, 3);
    add(0, 3'b001, 1); add(0, 3'b000, 6);
    // Chatter 1,0,1,1,0,1,1,1,1 then hold
    add(1, 3'b000, 1); add(0, 3'b000, 1); add(1, 3'b000, 2); add(0, 3'b000, 1);
    add(1, 3'b000, 4); add(1, 3'b000, 1); add(1, 3'b110, 1); add(1, 3'b100, 3);
    add(0, 3'b100, 5); add(0, 3'b001, 1); add(0, 3'b000, 2);

    // Reset state
    tick(); tick();
    check("reset_state", 0, {out, rise, fall}, 3'b000);
    check("reset_state_init1", 0, {out1, rise1, fall1}, 3'b100);

    // Release with in low and idle for 100 cycles
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      check("idle_low", k, {out, rise, fall}, 3'b000);
    end

    for (int r = 0; r < tbl.size(); r++) begin
      in_raw = tbl[r].in;
      tick();
      check("vec", r, {out, rise, fall}, tbl[r].exp);
    end

    // Reset asserted mid-PEND_HI aborts the filter
    in_raw = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("pend_pre_reset", k, {out, rise, fall}, 3'b000);
    end
    rst_n = 1'b0;
    #1;
    check("reset_async", 0, {out, rise, fall}, 3'b000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("in_reset", k, {out, rise, fall}, 3'b000);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("post_reset_hi", k, {out, rise, fall},
            (k < 6) ? 3'b000 : ((k == 6) ? 3'b110 : 3'b100));
    end

    // INIT=1, FILTER=1 instance
    rst1_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("init1_idle", k, {out1, rise1, fall1}, 3'b100);
    end
    in1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("f1_fall", k, {out1, rise1, fall1},
            (k < 3) ? 3'b100 : ((k == 3) ? 3'b001 : 3'b000));
    end
    in1 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("f1_rise", k, {out1, rise1, fall1},
            (k < 3) ? 3'b000 : ((k == 3) ? 3'b110 : 3'b100));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debounce_m.md
DEBOUNCE_M -- requirements
Module: debounce_m

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops; legal values >= 2.
REQ-002 SHALL have parameter FILTER, default 16, number of consecutive clocks the synchronized input must hold a new level before it is accepted; legal values >= 1.
REQ-003 SHALL have parameter INIT, default 1'b0, level assumed for input and output during and after reset.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in  input  1  raw asynchronous level (button, external trigger line).
REQ-007 SHALL have port out  output  1  debounced level.
REQ-008 SHALL have port rise  output  1  single-cycle pulse on out 0->1; drives the downstream pulse-former input.
REQ-009 SHALL have port fall  output  1  single-cycle pulse on out 1->0.

Function
REQ-010 SHALL pass in through a SYNC_STAGES-deep flop chain; the last stage is in_s. in_s reflects in after exactly SYNC_STAGES rising edges.
REQ-011 SHALL use a four-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-012 In STABLE_LO with in_s=1, SHALL enter PEND_HI and load the counter. In STABLE_HI with in_s=0, SHALL enter PEND_LO and load the counter.
REQ-013 In PEND_x with in_s at the target level, SHALL decrement the counter. On the terminal count it SHALL enter STABLE_x, update out and pulse rise or fall.
REQ-014 In PEND_x with in_s back at the old level, SHALL return to the previous STABLE state, discard the count, and leave out unchanged with no pulse.
REQ-015 Timing: when in_s holds the new level, out SHALL change on exactly the FILTER-th rising edge counted from and including the first edge that samples the new in_s value. Total in-to-out latency SHALL be SYNC_STAGES+FILTER edges.
REQ-016 With FILTER=1, SHALL bypass the PEND states; out SHALL follow in_s one edge later.
REQ-017 rise and fall SHALL be registered, high for exactly one cycle, in the same cycle out first shows the new level, and never asserted together.
REQ-018 Counter width SHALL be $clog2(FILTER+1). The counter SHALL never wrap; it SHALL hold 0 outside the PEND states.
REQ-019 Input toggling faster than FILTER cycles SHALL never change out, regardless of duration.
REQ-020 The FSM SHALL recover from illegal state encodings to STABLE_LO or STABLE_HI per out.

Reset
REQ-021 While rst_n=0, SHALL immediately force all sync flops to INIT, FSM to STABLE_LO/STABLE_HI per INIT, counter to 0, out=INIT, rise=0, fall=0.
REQ-022 Reset deassertion SHALL produce no rise/fall pulse, even when in differs from INIT; such a difference SHALL be filtered normally per REQ-015.
REQ-023 Reset asserted mid-PEND SHALL abort filtering with no pulse.

Structure
REQ-024 A shared package debounce_pkg SHALL hold the FSM state enum type deb_state_t.
REQ-025 The synchronizer chain SHALL be a sub-module sync_m (parameter STAGES, INIT), reusable by other blocks.
REQ-026 Outputs SHALL be driven from flops only; no combinational path from in to any output.

Verification (SYNC_STAGES=2, FILTER=4, INIT=0 unless stated)
REQ-027 Release reset with in=0 held 100 cycles -> out=0, rise=fall=0 throughout.
REQ-028 Step in 0->1 sampled at edge E0 and held -> out=1 and rise=1 at edge E0+6, rise low at E0+7; fall never asserted.
REQ-029 in high for 3 cycles then low -> out stays 0, no pulses. Repeat with 4 cycles -> out rises at E0+6, then falls 6 edges after the return to 0, with a single fall pulse.
REQ-030 in chatters 1,0,1,1,0,1,1,1,1 -> out rises only after the final 4-cycle run; exactly one rise pulse.
REQ-031 Assert rst_n=0 two cycles into PEND_HI -> out=0 immediately, no pulse. Release with in=1 -> rise exactly 6 edges after the first sampling edge.
REQ-032 INIT=1, FILTER=1: release reset with in=1 -> out=1, no pulses. Drop in -> out=0 and fall at edge E0+3.
